// File: rtl/bp_update_sched.sv
// Table-port scheduler for the two-level branch predictor: clears BHT/PHT after
// reset, then serialises queued resolved-branch updates as read-modify-writes.
module bp_update_sched #(
  parameter int unsigned BHT_DEPTH  = 10,
  parameter int unsigned PHT_DEPTH  = 6,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        upd_valid,
  input  logic [31:0]                 upd_pc,
  input  logic                        upd_take,
  output logic                        upd_ready,
  input  logic                        lk_req,
  output logic                        lk_stall,
  output logic                        init_busy,
  output logic                        sched_own,
  output logic [BHT_DEPTH-1:0]        bht_addr,
  output logic                        bht_we,
  output logic [PHT_DEPTH-1:0]        bht_wdata,
  input  logic [PHT_DEPTH-1:0]        bht_rdata,
  output logic [PHT_DEPTH-1:0]        pht_addr,
  output logic                        pht_we,
  output logic [1:0]                  pht_wdata,
  input  logic [1:0]                  pht_rdata,
  output logic [$clog2(FIFO_DEPTH):0] q_count
);

  localparam int unsigned PtrW       = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW       = PtrW + 1;
  localparam int unsigned SweepW     = BHT_DEPTH + 1;
  localparam int unsigned PhtEntries = 1 << PHT_DEPTH;

  localparam logic [2:0] S_INIT   = 3'd0;
  localparam logic [2:0] S_IDLE   = 3'd1;
  localparam logic [2:0] S_RD_BHT = 3'd2;
  localparam logic [2:0] S_RD_PHT = 3'd3;
  localparam logic [2:0] S_WRITE  = 3'd4;

  typedef struct packed {
    logic [BHT_DEPTH-1:0] idx;
    logic                 take;
  } updEntry_t;

  updEntry_t            fifoMem [FIFO_DEPTH];
  updEntry_t            head;
  logic [PtrW-1:0]      wrPtr;
  logic [PtrW-1:0]      rdPtr;
  logic [CntW-1:0]      count;
  logic                 full;
  logic                 push;
  logic                 pop;
  logic                 granted;

  logic [2:0]           state;
  logic [2:0]           stateNext;
  logic [BHT_DEPTH-1:0] sweepCnt;
  logic [BHT_DEPTH-1:0] sweepNext;
  logic [PHT_DEPTH-1:0] bhrQ;
  logic [PHT_DEPTH-1:0] bhrNext;
  logic                 phtInRange;
  logic                 unusedPcBits;

  // 2-bit saturating counter with Gray-ordered encoding SNT=00 WNT=01 WT=11 ST=10
  function automatic logic [1:0] satStep(input logic [1:0] ctr, input logic take);
    logic [1:0] res;
    res = ctr;
    case ({ctr, take})
      3'b00_1: res = 2'b01;
      3'b01_1: res = 2'b11;
      3'b11_1: res = 2'b10;
      3'b10_1: res = 2'b10;
      3'b10_0: res = 2'b11;
      3'b11_0: res = 2'b01;
      3'b01_0: res = 2'b00;
      3'b00_0: res = 2'b00;
      default: res = ctr;
    endcase
    return res;
  endfunction

  assign unusedPcBits = ^{upd_pc[31:BHT_DEPTH+2], upd_pc[1:0]};

  assign full      = (count == CntW'(FIFO_DEPTH));
  assign upd_ready = ~full;
  assign push      = upd_valid & ~full;
  assign q_count   = count;
  assign head      = fifoMem[rdPtr];

  // A full queue steals the port from fetch so updates cannot be starved forever
  assign granted   = ~lk_req | full;
  assign init_busy = (state == S_INIT);
  assign lk_stall  = lk_req & sched_own & ~init_busy;

  assign phtInRange = ({1'b0, sweepCnt} < SweepW'(PhtEntries));

  always_ff @(posedge clk) begin
    if (push) begin
      fifoMem[wrPtr] <= '{idx: upd_pc[BHT_DEPTH+1:2], take: upd_take};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (push) wrPtr <= wrPtr + PtrW'(1);
      if (pop)  rdPtr <= rdPtr + PtrW'(1);
      case ({push, pop})
        2'b10:   count <= count + CntW'(1);
        2'b01:   count <= count - CntW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_INIT;
      sweepCnt <= '0;
      bhrQ     <= '0;
    end else begin
      state    <= stateNext;
      sweepCnt <= sweepNext;
      bhrQ     <= bhrNext;
    end
  end

  always_comb begin
    stateNext = state;
    sweepNext = sweepCnt;
    bhrNext   = bhrQ;
    sched_own = 1'b0;
    bht_addr  = '0;
    bht_we    = 1'b0;
    bht_wdata = '0;
    pht_addr  = '0;
    pht_we    = 1'b0;
    pht_wdata = 2'b00;
    pop       = 1'b0;

    case (state)
      S_INIT: begin
        sched_own = 1'b1;
        bht_addr  = sweepCnt;
        bht_we    = rst;
        if (phtInRange) begin
          pht_addr = sweepCnt[PHT_DEPTH-1:0];
          pht_we   = rst;
        end
        if (sweepCnt == {BHT_DEPTH{1'b1}}) begin
          stateNext = S_IDLE;
          sweepNext = '0;
        end else begin
          sweepNext = sweepCnt + BHT_DEPTH'(1);
        end
      end

      S_IDLE: begin
        if (count != '0) stateNext = S_RD_BHT;
      end

      S_RD_BHT: begin
        sched_own = granted;
        bht_addr  = head.idx;
        stateNext = granted ? S_RD_PHT : S_RD_BHT;
      end

      S_RD_PHT: begin
        sched_own = granted;
        bht_addr  = head.idx;
        pht_addr  = bht_rdata;
        if (granted) begin
          bhrNext   = bht_rdata;
          stateNext = S_WRITE;
        end else begin
          stateNext = S_RD_BHT;
        end
      end

      S_WRITE: begin
        sched_own = granted;
        bht_addr  = head.idx;
        bht_wdata = {bhrQ[PHT_DEPTH-2:0], head.take};
        pht_addr  = bhrQ;
        pht_wdata = satStep(pht_rdata, head.take);
        if (granted) begin
          bht_we    = 1'b1;
          pht_we    = 1'b1;
          pop       = 1'b1;
          stateNext = ((count != CntW'(1)) || push) ? S_RD_BHT : S_IDLE;
        end else begin
          stateNext = S_RD_BHT;
        end
      end

      default: stateNext = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_bp_update_sched.sv
// Bench for bp_update_sched: SRAM models, a queue/table-level reference model
// checked every cycle, and directed scenarios with literal expectations.
module tb_bp_update_sched;

  localparam int unsigned BD = 10;
  localparam int unsigned PD = 6;
  localparam int unsigned FD = 4;
  localparam int unsigned BN = 1 << BD;
  localparam int unsigned PN = 1 << PD;
  localparam logic [BD-1:0] FETCH_BHT = 10'h3FF;
  localparam logic [PD-1:0] FETCH_PHT = 6'h3F;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          upd_valid = 1'b0;
  logic [31:0]   upd_pc = 32'h0;
  logic          upd_take = 1'b0;
  logic          lk_req = 1'b0;
  logic          upd_ready, lk_stall, init_busy, sched_own, bht_we, pht_we;
  logic [BD-1:0] bht_addr;
  logic [PD-1:0] bht_wdata, bht_rdata, pht_addr;
  logic [1:0]    pht_wdata, pht_rdata;
  logic [2:0]    q_count;

  always #5 clk = ~clk;

  bp_update_sched #(.BHT_DEPTH(BD), .PHT_DEPTH(PD), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .rst(rst),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_take(upd_take), .upd_ready(upd_ready),
    .lk_req(lk_req), .lk_stall(lk_stall), .init_busy(init_busy), .sched_own(sched_own),
    .bht_addr(bht_addr), .bht_we(bht_we), .bht_wdata(bht_wdata), .bht_rdata(bht_rdata),
    .pht_addr(pht_addr), .pht_we(pht_we), .pht_wdata(pht_wdata), .pht_rdata(pht_rdata),
    .q_count(q_count)
  );

  int nChecks = 0;
  int nPass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act === exp) nPass++;
    else $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Single-ported SRAMs, read-before-write, 1-cycle read latency
  logic [PD-1:0] bhtRam [BN];
  logic [1:0]    phtRam [PN];

  always @(posedge clk) begin
    logic [BD-1:0] ba;
    logic [PD-1:0] pa;
    ba = sched_own ? bht_addr : FETCH_BHT;
    pa = sched_own ? pht_addr : FETCH_PHT;
    if (sched_own && bht_we) bhtRam[bht_addr] <= bht_wdata;
    if (sched_own && pht_we) phtRam[pht_addr] <= pht_wdata;
    bht_rdata <= bhtRam[ba];
    pht_rdata <= phtRam[pa];
  end

  // Reference model: update queue, sweep progress, RMW step (0=waiting, 1..3 = read BHT/read PHT/write)
  typedef struct { logic [BD-1:0] idx; logic take; } ent_t;
  typedef struct { logic [BD-1:0] ba; logic [PD-1:0] bd; logic [PD-1:0] pa; logic [1:0] pd; } wr_t;

  ent_t          mq[$];
  bit            mInit  = 1'b1;
  int            mSweep = 0;
  int            mPhase = 0;
  logic [PD-1:0] shBht [BN];
  logic [1:0]    shPht [PN];
  wr_t           writeLog[$];
  int            stallCnt = 0;

  function automatic logic [1:0] satModel(input logic [1:0] enc, input logic t);
    int lvl;
    case (enc)
      2'b00:   lvl = 0;
      2'b01:   lvl = 1;
      2'b11:   lvl = 2;
      default: lvl = 3;
    endcase
    if (t) lvl = (lvl < 3) ? lvl + 1 : 3;
    else   lvl = (lvl > 0) ? lvl - 1 : 0;
    case (lvl)
      0:       return 2'b00;
      1:       return 2'b01;
      2:       return 2'b11;
      default: return 2'b10;
    endcase
  endfunction

  always @(posedge clk or negedge rst) begin
    bit            full, grant, pushOk;
    ent_t          e;
    logic [PD-1:0] bhr;
    if (!rst) begin
      mInit = 1'b1; mSweep = 0; mPhase = 0; mq.delete();
    end else begin
      full   = (mq.size() == FD);
      grant  = !lk_req || full;
      pushOk = upd_valid && !full;
      if (mInit) begin
        shBht[mSweep] = '0;
        if (mSweep < PN) shPht[mSweep] = 2'b00;
        mSweep++;
        if (mSweep == BN) mInit = 1'b0;
      end else begin
        case (mPhase)
          0: if (mq.size() != 0) mPhase = 1;
          1: if (grant) mPhase = 2;
          2: mPhase = grant ? 3 : 1;
          default: begin
            if (grant) begin
              e   = mq.pop_front();
              bhr = shBht[e.idx];
              shPht[bhr]   = satModel(shPht[bhr], e.take);
              shBht[e.idx] = {bhr[PD-2:0], e.take};
              mPhase = ((mq.size() != 0) || pushOk) ? 1 : 0;
            end else begin
              mPhase = 1;
            end
          end
        endcase
      end
      if (pushOk) mq.push_back('{upd_pc[BD+1:2], upd_take});
    end
  end

  always @(negedge clk) begin
    bit            full, grant, own, commit;
    logic [PD-1:0] bhr;
    full   = (mq.size() == FD);
    grant  = !lk_req || full;
    own    = mInit ? 1'b1 : ((mPhase == 0) ? 1'b0 : grant);
    commit = !mInit && (mPhase == 3) && grant;
    check("init_busy", 32'(init_busy), 32'(mInit));
    check("upd_ready", 32'(upd_ready), 32'(!full));
    check("q_count",   32'(q_count),   32'(mq.size()));
    check("sched_own", 32'(sched_own), 32'(own));
    check("lk_stall",  32'(lk_stall),  32'(lk_req && own && !mInit));
    check("bht_we",    32'(bht_we),    32'(mInit ? rst : commit));
    check("pht_we",    32'(pht_we),    32'(mInit ? (rst && mSweep < PN) : commit));
    if (mInit && rst) begin
      check("sweep_bht_addr",  32'(bht_addr),  32'(mSweep));
      check("sweep_bht_wdata", 32'(bht_wdata), 32'h0);
      if (mSweep < PN) begin
        check("sweep_pht_addr",  32'(pht_addr),  32'(mSweep));
        check("sweep_pht_wdata", 32'(pht_wdata), 32'h0);
      end
    end else if (commit) begin
      bhr = shBht[mq[0].idx];
      check("wr_bht_addr",  32'(bht_addr),  32'(mq[0].idx));
      check("wr_bht_wdata", 32'(bht_wdata), 32'({bhr[PD-2:0], mq[0].take}));
      check("wr_pht_addr",  32'(pht_addr),  32'(bhr));
      check("wr_pht_wdata", 32'(pht_wdata), 32'(satModel(shPht[bhr], mq[0].take)));
    end else if (!mInit && mPhase == 1 && grant) begin
      check("rd_bht_addr", 32'(bht_addr), 32'(mq[0].idx));
    end
    if (rst && bht_we && !init_busy) writeLog.push_back('{bht_addr, bht_wdata, pht_addr, pht_wdata});
    if (lk_stall) stallCnt++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] pc, input logic t);
    upd_valid = 1'b1; upd_pc = pc; upd_take = t;
    step();
    upd_valid = 1'b0;
  endtask

  task automatic waitWrites(input int n, input string name);
    int b;
    b = 0;
    while (writeLog.size() < n && b < 200) begin
      step();
      b++;
    end
    check({name, "_write_timeout"}, 32'(writeLog.size() >= n), 32'h1);
  endtask

  task automatic sweepRun(input string name);
    int busy, bwe, pwe, pbad;
    busy = 0; bwe = 0; pwe = 0; pbad = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (!init_busy) break;
      busy++;
      if (bht_we) bwe++;
      if (pht_we) begin
        pwe++;
        if (pht_wdata != 2'b00) pbad++;
      end
    end
    step();
    check({name, "_busy_cycles"}, 32'(busy), 32'd1024);
    check({name, "_bht_we_cycles"}, 32'(bwe), 32'd1024);
    check({name, "_pht_we_cycles"}, 32'(pwe), 32'd64);
    check({name, "_pht_wdata_nonzero"}, 32'(pbad), 32'd0);
  endtask

  task automatic checkTables(input string name);
    for (int i = 0; i < BN; i++) check({name, "_bht"}, 32'(bhtRam[i]), 32'(shBht[i]));
    for (int i = 0; i < PN; i++) check({name, "_pht"}, 32'(phtRam[i]), 32'(shPht[i]));
  endtask

  initial begin
    int   base;
    wr_t  w;
    logic [PD-1:0] bhrExp [4] = '{6'd1, 6'd3, 6'd7, 6'd15};
    logic [PD-1:0] paExp  [4] = '{6'd0, 6'd1, 6'd3, 6'd7};
    logic [1:0]    pdExp  [4] = '{2'b11, 2'b01, 2'b01, 2'b01};

    repeat (3) step();
    check("reset_init_busy", 32'(init_busy), 32'h1);
    check("reset_sched_own", 32'(sched_own), 32'h1);
    check("reset_bht_we",    32'(bht_we),    32'h0);
    check("reset_q_count",   32'(q_count),   32'h0);
    rst = 1'b1;

    // Clear sweep
    sweepRun("t1");

    // Single taken update
    base = writeLog.size();
    push(32'h1000_0040, 1'b1);
    waitWrites(base + 1, "t2");
    if (writeLog.size() > base) begin
      w = writeLog[base];
      check("t2_bht_addr",  32'(w.ba), 32'h010);
      check("t2_bht_wdata", 32'(w.bd), 32'h01);
      check("t2_pht_addr",  32'(w.pa), 32'h0);
      check("t2_pht_wdata", 32'(w.pd), 32'h1);
    end

    // Four back-to-back taken updates to one PC
    base = writeLog.size();
    for (int k = 0; k < 4; k++) push(32'h1000_0080, 1'b1);
    waitWrites(base + 4, "t3");
    for (int k = 0; k < 4; k++) begin
      if (writeLog.size() > base + k) begin
        w = writeLog[base + k];
        check("t3_bht_wdata", 32'(w.bd), 32'(bhrExp[k]));
        check("t3_pht_addr",  32'(w.pa), 32'(paExp[k]));
        check("t3_pht_wdata", 32'(w.pd), 32'(pdExp[k]));
      end
    end
    repeat (3) step();
    check("t3_q_count_final", 32'(q_count), 32'h0);

    // Fetch contention and full-queue steal
    lk_req = 1'b1;
    base = writeLog.size();
    stallCnt = 0;
    push(32'h0000_0200, 1'b0);
    push(32'h0000_0204, 1'b1);
    repeat (10) step();
    check("t4_no_write_contended", 32'(writeLog.size() - base), 32'h0);
    check("t4_no_stall_contended", 32'(stallCnt), 32'h0);
    push(32'h0000_0208, 1'b1);
    push(32'h0000_020C, 1'b0);
    repeat (8) step();
    check("t4_steal_stall_cycles", 32'(stallCnt), 32'd3);
    check("t4_count_after_steal",  32'(q_count),  32'd3);
    check("t4_steal_writes",       32'(writeLog.size() - base), 32'd1);
    lk_req = 1'b0;
    waitWrites(base + 4, "t4");
    repeat (3) step();

    // Fetch pulse while the PHT read is pending forces a restart
    base = writeLog.size();
    push(32'h0000_0300, 1'b0);
    step();
    step();
    lk_req = 1'b1;
    step();
    lk_req = 1'b0;
    waitWrites(base + 1, "t5a");
    push(32'h0000_0300, 1'b1);
    step();
    step();
    lk_req = 1'b1;
    step();
    lk_req = 1'b0;
    waitWrites(base + 2, "t5b");
    if (writeLog.size() >= base + 2) begin
      check("t5_first_pht_wdata",  32'(writeLog[base].pd),     32'h1);
      check("t5_second_bht_wdata", 32'(writeLog[base + 1].bd), 32'h1);
      check("t5_second_pht_wdata", 32'(writeLog[base + 1].pd), 32'h3);
    end
    repeat (3) step();
    checkTables("t5");

    // Reset during a stolen WRITE
    lk_req = 1'b1;
    push(32'h0000_0400, 1'b1);
    push(32'h0000_0404, 1'b1);
    push(32'h0000_0408, 1'b0);
    push(32'h0000_040C, 1'b1);
    step();
    step();
    base = writeLog.size();
    check("t6_in_write", 32'(bht_we), 32'h1);
    #1 rst = 1'b0;
    @(negedge clk);
    check("t6_init_busy", 32'(init_busy), 32'h1);
    check("t6_q_count",   32'(q_count),   32'h0);
    check("t6_upd_ready", 32'(upd_ready), 32'h1);
    check("t6_bht_we",    32'(bht_we),    32'h0);
    check("t6_lk_stall",  32'(lk_stall),  32'h0);
    step();
    check("t6_no_partial_write", 32'(writeLog.size() - base), 32'h0);
    rst = 1'b1;
    lk_req = 1'b0;
    sweepRun("t6");
    checkTables("t6");

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
